// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : decode_scoreboard
// Purpose  : Per-register pending-write scoreboard beside the decode stage.
//            Counts in-flight destination writes between decode issue and
//            regfile writeback and raises a combinational stall when a source
//            read hits a pending write or a destination counter is saturated.
// Ports    : clk_i            rising-edge clock
//            rst_ni           asynchronous active-low reset
//            dec_valid_i      decode holds a valid instruction
//            dec_use1_i/dec_ra1_i   source 1 read enable / address
//            dec_use2_i/dec_ra2_i   source 2 read enable / address
//            dec_wen_i/dec_rdst_i   destination write enable / address
//            wb_valid_i/wb_addr_i   writeback retire strobe / address
//            flush_i          squash all in-flight state
//            stall_o          decode must hold (combinational)
//            issue_fire_o     instruction leaves decode (combinational)
//            busy_mask_o      bit i set while register i has pending writes
//            err_underflow_o  sticky: writeback retired an untracked register
//            stall_cycles_o   wrapping count of stalled decode cycles
// Options  : SB_WB_BYPASS_EN  a source whose last pending write retires this
//            cycle is treated as ready (regfile write-through), and a
//            same-cycle retire to a saturated destination frees its slot.
// Revision : 1.0 - initial release
// ============================================================================
module decode_scoreboard #(
    parameter int NREG   = 32,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dec_valid_i,
    input  logic                    dec_use1_i,
    input  logic [$clog2(NREG)-1:0] dec_ra1_i,
    input  logic                    dec_use2_i,
    input  logic [$clog2(NREG)-1:0] dec_ra2_i,
    input  logic                    dec_wen_i,
    input  logic [$clog2(NREG)-1:0] dec_rdst_i,
    input  logic                    wb_valid_i,
    input  logic [$clog2(NREG)-1:0] wb_addr_i,
    input  logic                    flush_i,
    output logic                    stall_o,
    output logic                    issue_fire_o,
    output logic [NREG-1:0]         busy_mask_o,
    output logic                    err_underflow_o,
    output logic [PERF_W-1:0]       stall_cycles_o
);

    localparam int             AW      = $clog2(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  count_q [NREG];
    logic [CNT_W-1:0]  count_d [NREG];
    logic              err_underflow_q, err_underflow_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [NREG-1:0]   wb_hit;   // writeback targets register i this cycle
    logic [NREG-1:0]   pend;     // register i blocks a source read
    logic              raw1, raw2, sat;

    // ------------------------------------------------------------------
    // Per-register decode of writeback and pending status
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        assign wb_hit[i]      = wb_valid_i && (wb_addr_i == AW'(i));
        assign busy_mask_o[i] = (count_q[i] != '0);
`ifdef SB_WB_BYPASS_EN
        // Last pending write retiring now is visible through the regfile.
        assign pend[i] = (count_q[i] != '0) && !(wb_hit[i] && (count_q[i] == CNT_ONE));
`else
        assign pend[i] = (count_q[i] != '0);
`endif
    end

    // ------------------------------------------------------------------
    // Hazard detection and issue
    // ------------------------------------------------------------------
    assign raw1 = dec_use1_i && (dec_ra1_i != '0) && pend[dec_ra1_i];
    assign raw2 = dec_use2_i && (dec_ra2_i != '0) && pend[dec_ra2_i];
`ifdef SB_WB_BYPASS_EN
    // A retire to the same destination frees a slot for this write.
    assign sat  = dec_wen_i && (dec_rdst_i != '0) &&
                  (count_q[dec_rdst_i] == CNT_MAX) && !wb_hit[dec_rdst_i];
`else
    assign sat  = dec_wen_i && (dec_rdst_i != '0) &&
                  (count_q[dec_rdst_i] == CNT_MAX);
`endif

    assign stall_o      = dec_valid_i && (raw1 || raw2 || sat);
    assign issue_fire_o = dec_valid_i && !stall_o && !flush_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            count_d[r] = count_q[r];
        end
        // Register 0 is architecturally constant and never tracked.
        for (int r = 1; r < NREG; r++) begin
            logic inc, dec;
            inc = issue_fire_o && dec_wen_i && (dec_rdst_i == AW'(r));
            dec = wb_hit[r] && (count_q[r] != '0);
            if (inc && !dec) begin
                count_d[r] = count_q[r] + CNT_ONE;
            end else if (dec && !inc) begin
                count_d[r] = count_q[r] - CNT_ONE;
            end
        end
        count_d[0] = '0;
        // Flush overrides any same-cycle increment or retire.
        if (flush_i) begin
            for (int r = 0; r < NREG; r++) begin
                count_d[r] = '0;
            end
        end
    end

    // A retire is only an error when nothing was pending and the cycle
    // is not being squashed.
    assign err_underflow_d = err_underflow_q ||
                             (wb_valid_i && (wb_addr_i != '0) &&
                              (count_q[wb_addr_i] == '0) && !flush_i);

    assign stall_cycles_d  = (dec_valid_i && stall_o && !flush_i) ?
                             stall_cycles_q + PERF_W'(1) : stall_cycles_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREG; r++) begin
                count_q[r] <= '0;
            end
            err_underflow_q <= 1'b0;
            stall_cycles_q  <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                count_q[r] <= count_d[r];
            end
            err_underflow_q <= err_underflow_d;
            stall_cycles_q  <= stall_cycles_d;
        end
    end

    assign err_underflow_o = err_underflow_q;
    assign stall_cycles_o  = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_scoreboard
// Purpose  : Directed self-checking bench for decode_scoreboard. Expected
//            values are queued as each step is driven and popped in order
//            as the DUT outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        dec_valid, dec_use1, dec_use2, dec_wen;
    logic [4:0]  dec_ra1, dec_ra2, dec_rdst;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        stall, issue_fire, err_underflow;
    logic [31:0] busy_mask;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int sc     = 0;   // expected stall_cycles value

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sbq[$];

    decode_scoreboard #(.NREG(32), .CNT_W(2), .PERF_W(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .dec_valid_i     (dec_valid),
        .dec_use1_i      (dec_use1),
        .dec_ra1_i       (dec_ra1),
        .dec_use2_i      (dec_use2),
        .dec_ra2_i       (dec_ra2),
        .dec_wen_i       (dec_wen),
        .dec_rdst_i      (dec_rdst),
        .wb_valid_i      (wb_valid),
        .wb_addr_i       (wb_addr),
        .flush_i         (flush),
        .stall_o         (stall),
        .issue_fire_o    (issue_fire),
        .busy_mask_o     (busy_mask),
        .err_underflow_o (err_underflow),
        .stall_cycles_o  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] act);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", act);
        end else begin
            e = sbq.pop_front();
            assert (act === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, act, e.val);
            end
        end
    endtask

    // Compare the full visible output set against queued expectations.
    task automatic expect_all(input string tag, input logic st, input logic fire,
                              input logic [31:0] busy, input logic err,
                              input logic [31:0] cyc);
        push({tag, ".stall"}, 64'(st));
        push({tag, ".issue_fire"}, 64'(fire));
        push({tag, ".busy_mask"}, 64'(busy));
        push({tag, ".err_underflow"}, 64'(err));
        push({tag, ".stall_cycles"}, 64'(cyc));
        #2;
        pop_check(64'(stall));
        pop_check(64'(issue_fire));
        pop_check(64'(busy_mask));
        pop_check(64'(err_underflow));
        pop_check(64'(stall_cycles));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic u1, input logic [4:0] a1,
                         input logic w, input logic [4:0] rd,
                         input logic wbv, input logic [4:0] wba, input logic fl);
        dec_valid = v;  dec_use1 = u1; dec_ra1 = a1;
        dec_use2  = 1'b0; dec_ra2 = 5'd0;
        dec_wen   = w;  dec_rdst = rd;
        wb_valid  = wbv; wb_addr = wba; flush = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        expect_all("reset", 0, 1, 32'h0, 0, 0);
        #9;
        rst_n = 1'b1;                                       // t=12, between edges

        // Producer to r5, then dependent read of r5
        drive(1, 0, 0, 1, 5, 0, 0, 0);
        expect_all("s1_issue", 0, 1, 32'h0, 0, sc);
        step;
        drive(1, 1, 5, 0, 0, 0, 0, 0);
        expect_all("s1_raw", 1, 0, 32'h20, 0, sc);
        sc++;
        step;

        // Writeback of r5 while the dependent instruction waits
        drive(1, 1, 5, 0, 0, 1, 5, 0);
`ifdef SB_WB_BYPASS_EN
        expect_all("s2_wb", 0, 1, 32'h20, 0, sc);
`else
        expect_all("s2_wb", 1, 0, 32'h20, 0, sc);
        sc++;
`endif
        step;
        drive(1, 1, 5, 0, 0, 0, 0, 0);
        expect_all("s2_after", 0, 1, 32'h0, 0, sc);
        step;

        // Saturate r7
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 1, 7, 0, 0, 0);
            expect_all("s3_fill", 0, 1, (k == 0) ? 32'h0 : 32'h80, 0, sc);
            step;
        end
        expect_all("s3_sat", 1, 0, 32'h80, 0, sc);
        sc++;
        step;
        drive(0, 0, 0, 0, 0, 1, 7, 0);                      // count 3 -> 2
        expect_all("s3_wb1", 0, 0, 32'h80, 0, sc);
        step;
        drive(1, 0, 0, 1, 7, 1, 7, 0);                      // inc+dec: stays 2
        expect_all("s3_incdec", 0, 1, 32'h80, 0, sc);
        step;
        drive(1, 0, 0, 1, 7, 0, 0, 0);                      // 2 -> 3
        expect_all("s3_refill", 0, 1, 32'h80, 0, sc);
        step;
        expect_all("s3_sat2", 1, 0, 32'h80, 0, sc);
        sc++;
        step;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1, 7, 0);
            step;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_all("s3_drained", 0, 0, 32'h0, 0, sc);

        // Register 0 is never tracked
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        expect_all("s4_wr_r0", 0, 1, 32'h0, 0, sc);
        step;
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        expect_all("s4_rd_r0", 0, 1, 32'h0, 0, sc);
        step;

        // Flush with pending writes and a same-cycle retire
        drive(1, 0, 0, 1, 3, 0, 0, 0);
        step;
        step;
        drive(1, 0, 0, 1, 9, 0, 0, 0);
        step;
        drive(1, 1, 3, 0, 0, 1, 3, 1);
        expect_all("s5_flush", 1, 0, 32'h208, 0, sc);
        step;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_all("s5_after", 0, 0, 32'h0, 0, sc);
        drive(0, 0, 0, 0, 0, 1, 12, 1);                     // untracked retire under flush
        step;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_all("s5_flush_wb", 0, 0, 32'h0, 0, sc);

        // Underflow is sticky
        drive(0, 0, 0, 0, 0, 1, 12, 0);
        step;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_all("s6_uflow", 0, 0, 32'h0, 1, sc);
        step;
        expect_all("s6_sticky", 0, 0, 32'h0, 1, sc);

        // Asynchronous reset in the middle of a stall
        drive(1, 0, 0, 1, 4, 0, 0, 0);
        step;
        drive(1, 1, 4, 0, 0, 0, 0, 0);
        expect_all("s6_stall", 1, 0, 32'h10, 1, sc);
        #1;
        rst_n = 1'b0;
        #1;
        expect_all("s6_async_rst", 0, 1, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
